// File: rtl/step_arb_pkg.sv
// Shared types for the step/direction source arbiter.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   state_e     - arbiter FSM states (values pinned to legacy localparams)
//   prio_t      - {valid, index} result of a lowest-set-bit search
//   lowest_set  - lowest set bit of a request vector of up to 32 bits
package step_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN
    } state_e;

    // Widest request vector the helper can search.
    localparam int unsigned PRIO_MAX_SRC = 32;

    typedef struct packed {
        logic       vld;
        logic [4:0] idx;
    } prio_t;

    // Index 0 is highest priority, so scan downwards and let the lowest
    // set bit overwrite any higher one.
    function automatic prio_t lowest_set(input logic [PRIO_MAX_SRC-1:0] v);
        prio_t r;
        r.vld = 1'b0;
        r.idx = 5'd0;
        for (int i = PRIO_MAX_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                r.vld = 1'b1;
                r.idx = 5'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/step_prio_enc.sv
// Fixed-priority encoder: lowest set request bit wins (bit 0 highest).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of en.
//
// Ports:
//   en  [N-1:0]  request vector (N <= 32)
//   idx [IW-1:0] index of the lowest set bit (0 when vld is low)
//   vld          any request bit set
module step_prio_enc
    import step_arb_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  en,
    output logic [IW-1:0] idx,
    output logic          vld
);

    prio_t res;

    assign res = lowest_set(PRIO_MAX_SRC'(en));
    assign vld = res.vld;
    assign idx = IW'(res.idx);

endmodule

// File: rtl/step_source_arbiter.sv
// Selects which step/direction source drives the motor outputs, with clean pulse handover and direction setup.
// Latency: 1 cycle input-to-output in RUN; first pulse no earlier than 1 + DIR_SETUP_CYC cycles after a request.
// Backpressure: none; sources are never stalled, pulses from non-granted or masked sources are simply dropped.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   src_en[N]        per-source request, index 0 highest priority
//   src_dir[N]       per-source direction (1 = forward)
//   src_pulse[N]     per-source step pulse
//   freq_pulse       registered arbitrated step pulse
//   direc            registered arbitrated direction
//   grant[N]         one-hot owner of the outputs, 0 when idle
//   busy             high whenever the arbiter is not idle
//   pos_clr, pos_count (only with STEP_ARB_POS_COUNT_EN defined):
//                    clear input and signed 32-bit step position counter
module step_source_arbiter
    import step_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC       = 2,
    parameter int unsigned DIR_SETUP_CYC = 4,
    parameter int unsigned DRAIN_MAX_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_en,
    input  logic [NUM_SRC-1:0] src_dir,
    input  logic [NUM_SRC-1:0] src_pulse,
    output logic               freq_pulse,
    output logic               direc,
    output logic [NUM_SRC-1:0] grant,
    output logic               busy
`ifdef STEP_ARB_POS_COUNT_EN
    ,
    input  logic               pos_clr,
    output logic signed [31:0] pos_count
`endif
);

    localparam int unsigned IW      = $clog2(NUM_SRC);
    localparam int unsigned CNT_MAX = (DIR_SETUP_CYC > DRAIN_MAX_CYC) ? DIR_SETUP_CYC : DRAIN_MAX_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SETUP_LOAD = CW'(DIR_SETUP_CYC - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_MAX_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    state_e               state;
    logic [IW-1:0]        gidx;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        dcnt;
    logic                 armed;

    logic [IW-1:0]        sel_idx;
    logic                 sel_vld;
    logic                 sel_same;
    logic                 src_g;
    logic                 dir_g;
    logic                 do_load;
    logic [NUM_SRC-1:0]   sel_onehot;

    step_prio_enc #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_prio (
        .en  (src_en),
        .idx (sel_idx),
        .vld (sel_vld)
    );

    // Losing the request and being preempted look the same here: either
    // way the current owner is no longer the winner.
    assign sel_same   = sel_vld && (sel_idx == gidx);
    assign src_g      = src_pulse[gidx];
    assign dir_g      = src_dir[gidx];
    assign sel_onehot = {{(NUM_SRC-1){1'b0}}, 1'b1} << sel_idx;

    // A new owner is only loaded once no pulse is on the output.
    assign do_load = sel_vld && ((state == IDLE) || ((state == DRAIN) && !freq_pulse));

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gidx       <= '0;
            grant      <= '0;
            direc      <= 1'b0;
            freq_pulse <= 1'b0;
            cnt        <= '0;
            dcnt       <= '0;
            armed      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    freq_pulse <= 1'b0;
                    direc      <= 1'b0;
                    grant      <= '0;
                end
                SETUP: begin
                    freq_pulse <= 1'b0;
                    if (!sel_same) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end else if (cnt == '0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                RUN: begin
                    // A pulse already high when RUN starts must not be
                    // passed mid-way; wait for it to be seen low first.
                    if (!src_g) begin
                        armed <= 1'b1;
                    end
                    freq_pulse <= src_g & armed;
                    if (!sel_same) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end else if ((dir_g != direc) && !freq_pulse) begin
                        // Output is forced low on the edge direc moves so
                        // no pulse can rise together with the new direction.
                        direc      <= dir_g;
                        cnt        <= SETUP_LOAD;
                        armed      <= 1'b0;
                        freq_pulse <= 1'b0;
                        state      <= SETUP;
                    end
                end
                DRAIN: begin
                    if (freq_pulse) begin
                        // Finish the in-flight pulse, bounded in case the
                        // old source is stuck high.
                        if (src_g && (dcnt < DRAIN_LAST)) begin
                            dcnt <= dcnt + CNT_ONE;
                        end else begin
                            freq_pulse <= 1'b0;
                        end
                    end else if (!sel_vld) begin
                        state <= IDLE;
                        grant <= '0;
                        direc <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (do_load) begin
                gidx  <= sel_idx;
                grant <= sel_onehot;
                direc <= src_dir[sel_idx];
                cnt   <= SETUP_LOAD;
                armed <= 1'b0;
                state <= SETUP;
            end
        end
    end

`ifdef STEP_ARB_POS_COUNT_EN
    logic fp_d;

    // Counts rising edges of the registered output; direc is stable for
    // the whole pulse, so sampling it one cycle late is safe.
    always_ff @(posedge clk) begin
        if (rst) begin
            fp_d      <= 1'b0;
            pos_count <= '0;
        end else begin
            fp_d <= freq_pulse;
            if (pos_clr) begin
                pos_count <= '0;
            end else if (freq_pulse && !fp_d) begin
                pos_count <= direc ? (pos_count + 32'sd1) : (pos_count - 32'sd1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_step_source_arbiter.sv
// Self-checking bench for step_source_arbiter: directed handover scenarios plus randomized rule checking.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_step_source_arbiter;

    localparam int unsigned NSRC  = 2;
    localparam int unsigned DSET  = 4;
    localparam int unsigned DMAX  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  src_en;
    logic [1:0]  src_dir;
    logic [1:0]  src_pulse;
    logic        freq_pulse;
    logic        direc;
    logic [1:0]  grant;
    logic        busy;
`ifdef STEP_ARB_POS_COUNT_EN
    logic               pos_clr;
    logic signed [31:0] pos_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    step_source_arbiter #(
        .NUM_SRC       (NSRC),
        .DIR_SETUP_CYC (DSET),
        .DRAIN_MAX_CYC (DMAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_en     (src_en),
        .src_dir    (src_dir),
        .src_pulse  (src_pulse),
        .freq_pulse (freq_pulse),
        .direc      (direc),
        .grant      (grant),
        .busy       (busy)
`ifdef STEP_ARB_POS_COUNT_EN
        ,
        .pos_clr    (pos_clr),
        .pos_count  (pos_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Randomized-phase state
    int         ph [2];
    int         per[2];
    int         wid[2];
    logic [1:0] p_grant;
    logic       p_fp;
    logic       p_dir;
    int         since;
    int         hi_run;
    int         en_age;
    int         seg;
    logic [1:0] new_en;
    logic [1:0] win;

    initial begin
        rst       = 1'b1;
        src_en    = 2'b00;
        src_dir   = 2'b00;
        src_pulse = 2'b00;
`ifdef STEP_ARB_POS_COUNT_EN
        pos_clr   = 1'b0;
`endif
        step(2);
        check("rst_fp",    32'(freq_pulse), 32'd0);
        check("rst_direc", 32'(direc),      32'd0);
        check("rst_grant", 32'(grant),      32'd0);
        check("rst_busy",  32'(busy),       32'd0);
`ifdef STEP_ARB_POS_COUNT_EN
        check("rst_pos",   pos_count,       32'd0);
`endif
        rst = 1'b0;
        step(2);
        check("idle_busy", 32'(busy), 32'd0);

        // Source 1 alone, pulses every 10 cycles; earliest pass after setup.
        src_en  = 2'b10;
        src_dir = 2'b10;
        src_pulse = 2'b00;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            check("t1_fp",    32'(freq_pulse), 32'(k == 11 || k == 21 || k == 31));
            check("t1_grant", 32'(grant),      32'h2);
            check("t1_direc", 32'(direc),      32'd1);
            src_pulse = ((k % 10) == 0 && k < 40) ? 2'b10 : 2'b00;
        end

        // Preemption by source 0 in the middle of a 3-cycle pulse.
        src_pulse = 2'b10;
        src_en    = 2'b10;
        for (int s = 1; s <= 10; s++) begin
            step(1);
            check("t2_fp",    32'(freq_pulse), 32'(s <= 3));
            check("t2_grant", 32'(grant),      (s <= 4) ? 32'h2 : 32'h1);
            check("t2_direc", 32'(direc),      32'(s <= 4));
            check("t2_busy",  32'(busy),       32'd1);
            src_en    = 2'b11;
            src_pulse = (s <= 2) ? 2'b10 : 2'b00;
        end

        // Direction reversal requested while a pulse is on the output.
        src_pulse = 2'b01;
        src_dir   = 2'b10;
        for (int s = 1; s <= 16; s++) begin
            step(1);
            check("t3_fp",    32'(freq_pulse), 32'(s == 1 || s == 2 || s == 14));
            check("t3_direc", 32'(direc),      32'(s >= 4));
            check("t3_grant", 32'(grant),      32'h1);
            src_dir   = 2'b11;
            src_pulse = (s == 1 || (s >= 3 && s <= 11) || s == 13) ? 2'b01 : 2'b00;
        end

        // Stuck pulse on source 1 when its request drops.
        src_en    = 2'b10;
        src_pulse = 2'b00;
        step(10);
        check("t4_grant", 32'(grant), 32'h2);
        check("t4_direc", 32'(direc), 32'd1);
        src_pulse = 2'b10;
        for (int s = 1; s <= 68; s++) begin
            step(1);
            check("t4_fp",   32'(freq_pulse), 32'(s <= 65));
            check("t4_busy", 32'(busy),       32'(s <= 66));
            src_en = 2'b00;
        end
        check("t4_idle_grant", 32'(grant), 32'd0);
        check("t4_idle_direc", 32'(direc), 32'd0);

        // Reset while a pulse is high, then restart with the request held.
        src_en    = 2'b10;
        src_pulse = 2'b00;
        step(8);
        src_pulse = 2'b10;
        step(1);
        check("t5_fp_pre", 32'(freq_pulse), 32'd1);
        rst = 1'b1;
        step(1);
        check("t5_rst_fp",    32'(freq_pulse), 32'd0);
        check("t5_rst_grant", 32'(grant),      32'd0);
        check("t5_rst_direc", 32'(direc),      32'd0);
        check("t5_rst_busy",  32'(busy),       32'd0);
        rst = 1'b0;
        step(1);
        check("t5_re_grant", 32'(grant),      32'h2);
        check("t5_re_direc", 32'(direc),      32'd1);
        check("t5_re_busy",  32'(busy),       32'd1);
        check("t5_re_fp",    32'(freq_pulse), 32'd0);

`ifdef STEP_ARB_POS_COUNT_EN
        // Position: 5 forward, 2 reverse, then a clear colliding with a step.
        src_pulse = 2'b00;
        pos_clr   = 1'b1;
        step(1);
        pos_clr   = 1'b0;
        step(8);
        check("pc_zero", pos_count, 32'd0);
        for (int i = 0; i < 5; i++) begin
            src_pulse = 2'b10; step(1);
            src_pulse = 2'b00; step(3);
        end
        step(2);
        check("pc_fwd", pos_count, 32'd5);
        src_dir = 2'b01;
        step(12);
        for (int i = 0; i < 2; i++) begin
            src_pulse = 2'b10; step(1);
            src_pulse = 2'b00; step(3);
        end
        step(2);
        check("pc_net", pos_count, 32'd3);
        src_pulse = 2'b10;
        step(1);
        check("pc_rise", 32'(freq_pulse), 32'd1);
        pos_clr   = 1'b1;
        src_pulse = 2'b00;
        step(1);
        pos_clr   = 1'b0;
        step(3);
        check("pc_clr_step", pos_count, 32'd0);
`endif

        // Randomized traffic checked against the arbiter's guarantees.
        rst       = 1'b1;
        src_en    = 2'b00;
        src_pulse = 2'b00;
        src_dir   = 2'b00;
        step(2);
        rst     = 1'b0;
        p_grant = 2'b00;
        p_fp    = 1'b0;
        p_dir   = 1'b0;
        since   = 0;
        hi_run  = 0;
        en_age  = 0;
        seg     = 0;
        for (int i = 0; i < 2; i++) begin
            ph[i]  = 0;
            per[i] = 6 + 3 * i;
            wid[i] = 1;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step(1);
            check("rnd_onehot", 32'($onehot0(grant)), 32'd1);
            check("rnd_busy",   32'(busy), 32'(grant != 2'b00));
            if (direc !== p_dir) begin
                check("rnd_dir_hold", 32'({p_fp, freq_pulse}), 32'd0);
                since = 0;
            end else begin
                since = since + 1;
            end
            if (freq_pulse)
                check("rnd_fp_src", 32'(|(p_grant & src_pulse)), 32'd1);
            if (freq_pulse && !p_fp)
                check("rnd_dir_setup", 32'(since >= DSET), 32'd1);
            if (!freq_pulse && p_fp)
                check("rnd_trunc", 32'(((p_grant & src_pulse) == 2'b00) || hi_run >= DMAX), 32'd1);
            hi_run = freq_pulse ? hi_run + 1 : 0;
            if (en_age >= 80) begin
                win = src_en & (~src_en + 2'b01);
                check("rnd_settle_grant", 32'(grant), 32'(win));
                check("rnd_settle_busy",  32'(busy),  32'(src_en != 2'b00));
            end
            p_grant = grant;
            p_fp    = freq_pulse;
            p_dir   = direc;

            seg = seg - 1;
            if (seg <= 0) begin
                new_en = 2'($urandom_range(0, 3));
                if (new_en != src_en) en_age = 0;
                src_en = new_en;
                seg    = $urandom_range(5, 150);
            end
            en_age = en_age + 1;
            for (int i = 0; i < 2; i++) begin
                ph[i] = ph[i] + 1;
                if (ph[i] >= per[i]) begin
                    ph[i]  = 0;
                    per[i] = $urandom_range(4, 14);
                    wid[i] = $urandom_range(1, 3);
                end
                src_pulse[i] = (ph[i] < wid[i]);
                if ($urandom_range(0, 30) == 0) src_dir[i] = ~src_dir[i];
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/step_source_arbiter.md
# step_source_arbiter

Parametrised arbiter selecting which of NUM_SRC step/direction generators (homing, S-curve motion planner, jog, …) drives the motor's step-pulse and direction outputs. It sits between the per-source pulse generators and the PWM/driver output stage. It adds three guarantees:
- fixed priority across any number of sources;
- no truncated or spliced step pulses at handover;
- a guaranteed direction-setup interval before the first pulse after any direction change.

## Interface
- NUM_SRC, 2, number of pulse sources (≥2); index 0 is highest priority (homing)
- DIR_SETUP_CYC, 4, clk cycles direc must be stable before a step may pass (≥1)
- DRAIN_MAX_CYC, 64, maximum cycles a pulse already in flight is held high at handover

Ports:
- clk  input  1  system clock
- rst  input  1  reset (one clock; synchronous, active-high)
- src_en  input  NUM_SRC  per-source enable/request
- src_dir  input  NUM_SRC  per-source direction (1 = forward)
- src_pulse  input  NUM_SRC  per-source step pulse
- freq_pulse  output  1  arbitrated step pulse (registered)
- direc  output  1  arbitrated direction (registered)
- grant  output  NUM_SRC  one-hot active source, 0 when none
- busy  output  1  high whenever state ≠ IDLE

## Operation
- sel: the lowest set index of src_en. It is "none" when src_en == 0.
- States:
  - IDLE:
    - freq_pulse=0, direc=0, grant=0.
    - If sel valid: grant<=onehot(sel), direc<=src_dir[sel], cnt<=DIR_SETUP_CYC-1, armed<=0, go SETUP.
  - SETUP:
    - freq_pulse=0, direc held.
    - If sel ≠ granted index: go DRAIN (nothing is in flight, so DRAIN exits next cycle).
    - Else if cnt==0: go RUN; else cnt--.
  - RUN:
    - armed<=1 once src_pulse[g]==0 is sampled.
    - freq_pulse <= src_pulse[g] & armed. A pulse already high at entry is masked until it falls.
    - If sel ≠ g: go DRAIN.
    - Else if src_dir[g] ≠ direc and freq_pulse==0: direc<=src_dir[g], cnt<=DIR_SETUP_CYC-1, armed<=0, go SETUP.
    - A direction change seen while freq_pulse==1 waits until the pulse falls.
  - DRAIN:
    - If freq_pulse==1: keep it high while src_pulse[g]==1 and dcnt<DRAIN_MAX_CYC-1. On exit condition freq_pulse<=0.
    - When freq_pulse==0: if sel valid, load as in IDLE and go SETUP; else go IDLE.
- Priority preemption (a lower index asserting en) and loss of en are both handled by DRAIN; the two paths behave identically.
- Counter widths: $clog2(max(DIR_SETUP_CYC,DRAIN_MAX_CYC)+1). The counters saturate and never wrap.
- Simultaneous sel change and direction change in RUN: the sel change wins (go DRAIN).

## Timing
- Reset values: freq_pulse=0, direc=0, grant=0, busy=0, state=IDLE, all counters=0. rst mid-pulse drops freq_pulse on the next edge.
- Latency:
  - IDLE→first possible output pulse = 1 + DIR_SETUP_CYC cycles after src_en rises.
  - In RUN, freq_pulse and direc lag the inputs by 1 cycle.
- No output pulse is shorter than its source pulse, except when cut by the DRAIN_MAX_CYC timeout or rst.
- direc never changes while freq_pulse==1, nor within DIR_SETUP_CYC cycles before a freq_pulse rise.

## Configuration
- STEP_ARB_POS_COUNT_EN defined:
  - Adds ports pos_clr (input, 1) and pos_count (output, 32, signed).
  - On each registered rising edge of freq_pulse, pos_count increments if direc==1 and decrements otherwise, wrapping two's-complement.
  - rst and pos_clr reset it to 0; pos_clr takes precedence over a simultaneous step.
- Undefined: the ports and counter are absent; behaviour is otherwise identical.

## Structure
- Package step_arb_pkg:
  - state enum (IDLE, SETUP, RUN, DRAIN);
  - a function returning the lowest-set-bit index plus valid flag.
- Sub-module step_prio_enc (parametrised priority encoder: src_en → index, valid). Kept separate for reuse by other arbiters.

## Test plan
- NUM_SRC=2, DIR_SETUP_CYC=4: assert src_en=2'b10, src_dir[1]=1, pulse src 1 every 10 cycles → grant=2'b10, direc=1 after 1 cycle, first freq_pulse no earlier than cycle 5, then 1-cycle-delayed copies.
- Preemption: while src 1 runs with a 3-cycle-high pulse in flight, raise src_en[0] mid-pulse → freq_pulse stays high until src_pulse[1] falls, then grant=2'b01 and 4 setup cycles with freq_pulse=0.
- Direction reversal in RUN with src_pulse held high at entry → direc flips only after the pulse falls; the next pulse is masked until a low is seen and DIR_SETUP_CYC has elapsed.
- Stuck pulse: src_pulse[1] held high, drop src_en[1] → freq_pulse falls after exactly DRAIN_MAX_CYC=64 cycles, then IDLE with busy=0.
- rst asserted in RUN with freq_pulse=1 → next edge: all outputs 0 and state IDLE. Releasing rst with src_en=1 restarts setup.
- STEP_ARB_POS_COUNT_EN: 5 forward pulses then 2 reverse → pos_count=3. pos_clr coincident with a step → pos_count=0.
